// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 single-bit mux: walks the enabled channels in ascending order,
// samples y after a programmable dwell, and publishes the full vector once per scan.
module mux_scan_sequencer #(
   parameter int DWELL = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             continuous,
   input  logic [3:0]       ch_mask,
   input  logic             y_in,
   output logic             s0,
   output logic             s1,
   output logic             busy,
   output logic [3:0]       sample_vec,
   output logic             vec_valid,
   output logic [CNT_W-1:0] scan_cnt
);

   // state | meaning
   // IDLE  | selects parked at 00, waiting for start with a non-empty mask
   // SCAN  | dwelling on / sampling the enabled channels of mask_q in ascending order
   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state, state_nxt;
   logic [3:0]       mask_q, mask_nxt;
   logic [3:0]       shadow, shadow_nxt, shadow_smp;
   logic [3:0]       vec_nxt;
   logic [1:0]       ch, ch_nxt;
   logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
   logic [CNT_W-1:0] scan_nxt;
   logic             valid_nxt;
   logic             dwell_done;
   logic             last_ch;

   function automatic logic [1:0] lowest_ch(input logic [3:0] m);
      lowest_ch = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (m[i]) lowest_ch = 2'(i);
   endfunction

   // Returns c itself when no enabled channel lies above c.
   function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] c);
      next_ch = c;
      for (int i = 3; i >= 0; i--)
         if (m[i] && (i > int'(c))) next_ch = 2'(i);
   endfunction

   assign dwell_done = (dwell_cnt == CNT_W'(DWELL - 1));
   assign last_ch    = (next_ch(mask_q, ch) == ch);

   always_comb begin
      state_nxt  = state;
      mask_nxt   = mask_q;
      ch_nxt     = ch;
      dwell_nxt  = dwell_cnt;
      shadow_nxt = shadow;
      vec_nxt    = sample_vec;
      valid_nxt  = 1'b0;
      scan_nxt   = scan_cnt;
      shadow_smp = shadow;
      shadow_smp[ch] = y_in;
      case (state)
         IDLE: begin
            if (start && (ch_mask != 4'd0)) begin
               state_nxt  = SCAN;
               mask_nxt   = ch_mask;
               ch_nxt     = lowest_ch(ch_mask);
               dwell_nxt  = '0;
               shadow_nxt = '0;
            end
         end
         SCAN: begin
            if (!dwell_done) begin
               dwell_nxt = dwell_cnt + CNT_W'(1);
            end else begin
               dwell_nxt  = '0;
               shadow_nxt = shadow_smp;
               if (!last_ch) begin
                  ch_nxt = next_ch(mask_q, ch);
               end else begin
                  // Publish includes the sample taken on this very edge.
                  vec_nxt   = shadow_smp & mask_q;
                  valid_nxt = 1'b1;
                  scan_nxt  = scan_cnt + CNT_W'(1);
                  if (continuous && (ch_mask != 4'd0)) begin
                     mask_nxt   = ch_mask;
                     shadow_nxt = '0;
                     ch_nxt     = lowest_ch(ch_mask);
                  end else begin
                     state_nxt = IDLE;
                     ch_nxt    = 2'd0;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mask_q     <= '0;
         ch         <= '0;
         dwell_cnt  <= '0;
         shadow     <= '0;
         sample_vec <= '0;
         vec_valid  <= 1'b0;
         scan_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         mask_q     <= mask_nxt;
         ch         <= ch_nxt;
         dwell_cnt  <= dwell_nxt;
         shadow     <= shadow_nxt;
         sample_vec <= vec_nxt;
         vec_valid  <= valid_nxt;
         scan_cnt   <= scan_nxt;
      end
   end

   assign busy     = (state == SCAN);
   assign {s1, s0} = busy ? ch : 2'b00;

endmodule
